// File: rtl/binary_search_controller_if.sv
// Command/status bundle between the binary search controller (master) and
// its datapath plus user request (slave).
interface binary_search_controller_if;
    logic       start;
    logic [7:0] data_ans;
    logic [5:0] size;
    logic [4:0] addr;
    logic [7:0] q;
    logic       load_data;
    logic       data_big;
    logic       data_small;
    logic       found_ctrl;
    logic       notFound_ctrl;
    logic       check_zero;
    logic       busy;

    modport master (
        input  start, data_ans, size, addr, q,
        output load_data, data_big, data_small, found_ctrl, notFound_ctrl,
               check_zero, busy
    );

    modport slave (
        output start, data_ans, size, addr, q,
        input  load_data, data_big, data_small, found_ctrl, notFound_ctrl,
               check_zero, busy
    );
endinterface

// File: rtl/binary_search_controller.sv
// Moore controller sequencing a binary search over a 32x8 sorted RAM datapath.
// Optional macro BSC_PROBE_COUNT_EN adds the probes output (CMP cycles this search).
module binary_search_controller (
    input  logic                          clk,
    input  logic                          reset,
    binary_search_controller_if.master    bus
`ifdef BSC_PROBE_COUNT_EN
    ,
    output logic [2:0]                    probes
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_A,
        WAIT_B,
        CMP,
        DONE
    } state_t;

    state_t r_state;
    logic   r_zeroTried;
    logic   r_loadData;
    logic   r_dataBig;
    logic   r_dataSmall;
    logic   r_foundCtrl;
    logic   r_notFoundCtrl;
    logic   r_checkZero;
    logic   r_busy;

    logic   w_match;
    logic   w_keyAbove;
    logic   w_wideWindow;
    logic   w_tryZero;

    assign w_match      = (bus.q == bus.data_ans);
    assign w_keyAbove   = (bus.data_ans > bus.q);
    assign w_wideWindow = (bus.size > 6'd2);
    // Last window of two only hides address 0 when the key sits below mem[1].
    assign w_tryZero    = (bus.size == 6'd2) && !w_keyAbove && (bus.addr == 5'd1);

    // Commands are registered on the edge leaving CMP, so they are seen by the
    // datapath in the following cycle while the RAM settles in WAIT_A/WAIT_B.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_zeroTried    <= 1'b0;
            r_loadData     <= 1'b1;
            r_dataBig      <= 1'b0;
            r_dataSmall    <= 1'b0;
            r_foundCtrl    <= 1'b0;
            r_notFoundCtrl <= 1'b0;
            r_checkZero    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_loadData     <= 1'b0;
            r_dataBig      <= 1'b0;
            r_dataSmall    <= 1'b0;
            r_foundCtrl    <= 1'b0;
            r_notFoundCtrl <= 1'b0;
            r_checkZero    <= 1'b0;
            r_busy         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state     <= WAIT_A;
                        r_zeroTried <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_loadData  <= 1'b1;
                    end
                end
                WAIT_A: begin
                    r_state <= WAIT_B;
                    r_busy  <= 1'b1;
                end
                WAIT_B: begin
                    r_state <= CMP;
                    r_busy  <= 1'b1;
                end
                CMP: begin
                    if (w_match) begin
                        r_foundCtrl    <= 1'b1;
                        r_state        <= DONE;
                    end else if (r_zeroTried) begin
                        r_notFoundCtrl <= 1'b1;
                        r_state        <= DONE;
                    end else if (w_wideWindow) begin
                        r_dataBig      <= w_keyAbove;
                        r_dataSmall    <= !w_keyAbove;
                        r_state        <= WAIT_A;
                        r_busy         <= 1'b1;
                    end else if (w_tryZero) begin
                        r_checkZero    <= 1'b1;
                        r_zeroTried    <= 1'b1;
                        r_state        <= WAIT_A;
                        r_busy         <= 1'b1;
                    end else begin
                        r_notFoundCtrl <= 1'b1;
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        r_state    <= IDLE;
                        r_loadData <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_loadData <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_data     = r_loadData;
    assign bus.data_big      = r_dataBig;
    assign bus.data_small    = r_dataSmall;
    assign bus.found_ctrl    = r_foundCtrl;
    assign bus.notFound_ctrl = r_notFoundCtrl;
    assign bus.check_zero    = r_checkZero;
    assign bus.busy          = r_busy;

`ifdef BSC_PROBE_COUNT_EN
    logic [2:0] r_probes;

    // Held through DONE so the final count stays readable until the next IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_probes <= 3'd0;
        end else if (r_state == IDLE) begin
            r_probes <= 3'd0;
        end else if (r_state == CMP) begin
            r_probes <= r_probes + 3'd1;
        end
    end

    assign probes = r_probes;
`endif

endmodule

// File: tb/tb_binary_search_controller.sv
// Bench for binary_search_controller: datapath and registered-address RAM
// (mem[i] = 2*i+1) modelled here, directed searches with hand-computed results.
module tb_binary_search_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] keyIn = 8'd0;
    logic [7:0] mem [0:31];
    logic [4:0] ramAddr;
    logic       found;
    logic       notFound;
    int         checks = 0;
    int         errors = 0;

    binary_search_controller_if bus ();

`ifdef BSC_PROBE_COUNT_EN
    logic [2:0] probes;
`endif

    binary_search_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BSC_PROBE_COUNT_EN
        ,
        .probes(probes)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i + 1);
    end

    always @(posedge clk) ramAddr <= bus.addr;
    assign bus.q = mem[ramAddr];

    // Datapath: window starts at addr 16 / size 32 and halves on every move.
    always @(posedge clk) begin
        if (bus.load_data) begin
            bus.data_ans <= keyIn;
            bus.addr     <= 5'd16;
            bus.size     <= 6'd32;
            found        <= 1'b0;
            notFound     <= 1'b0;
        end else begin
            if (bus.data_big) begin
                bus.addr <= bus.addr + 5'(bus.size >> 2);
                bus.size <= bus.size >> 1;
            end
            if (bus.data_small) begin
                bus.addr <= bus.addr - 5'(bus.size >> 2);
                bus.size <= bus.size >> 1;
            end
            if (bus.check_zero) bus.addr <= 5'd0;
            if (bus.found_ctrl) found <= 1'b1;
            if (bus.notFound_ctrl) notFound <= 1'b1;
        end
    end

    // Cycle c is the one following the (c-1)-th edge after the edge that samples start.
    task automatic runSearch(input logic [7:0] key, input bit hold,
                             output int foundCyc, output int notFoundCyc,
                             output int zeroCnt, output logic [4:0] zeroAddr,
                             output int multiCmd);
        int cmdCnt;
        foundCyc = -1; notFoundCyc = -1; zeroCnt = 0; zeroAddr = 5'd0; multiCmd = 0;
        keyIn = key;
        bus.start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1 && !hold) bus.start = 1'b0;
            cmdCnt = int'(bus.load_data) + int'(bus.data_big) + int'(bus.data_small)
                   + int'(bus.found_ctrl) + int'(bus.notFound_ctrl) + int'(bus.check_zero);
            if (cmdCnt > 1) multiCmd++;
            if (bus.check_zero) begin
                if (zeroCnt == 0) zeroAddr = bus.addr;
                zeroCnt++;
            end
            if (bus.found_ctrl) foundCyc = c;
            if (bus.notFound_ctrl) notFoundCyc = c;
            if (foundCyc >= 0 || notFoundCyc >= 0) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic dropStart();
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.load_data !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_load_data: got %b, want 1", bus.load_data);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy: got %b, want 0", bus.busy);
        end
        checks++;
        if ({bus.data_big, bus.data_small, bus.found_ctrl, bus.notFound_ctrl, bus.check_zero} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_cmds: got %b, want 00000",
                {bus.data_big, bus.data_small, bus.found_ctrl, bus.notFound_ctrl, bus.check_zero});
        end
`ifdef BSC_PROBE_COUNT_EN
        checks++;
        if (probes !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_probes: got %0d, want 0", probes);
        end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.load_data !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset: load_data=%b busy=%b, want 1/0",
                bus.load_data, bus.busy);
        end
    endtask

    task automatic test_first_probe();
        int fc, nfc, zc, mc;
        logic [4:0] za;
        runSearch(8'd33, 1'b0, fc, nfc, zc, za, mc);
        checks++;
        if (fc !== 4) begin
            errors++; $display("[TB] FAIL first_probe_latency: got cycle %0d, want 4", fc);
        end
        checks++;
        if (found !== 1'b1 || bus.addr !== 5'd16) begin
            errors++; $display("[TB] FAIL first_probe_result: found=%b addr=%0d, want 1/16", found, bus.addr);
        end
        checks++;
        if (mc !== 0) begin
            errors++; $display("[TB] FAIL first_probe_onehot: got %0d overlap cycles, want 0", mc);
        end
`ifdef BSC_PROBE_COUNT_EN
        checks++;
        if (probes !== 3'd1) begin
            errors++; $display("[TB] FAIL first_probe_probes: got %0d, want 1", probes);
        end
`endif
        dropStart();
    endtask

    task automatic test_max_key();
        int fc, nfc, zc, mc;
        logic [4:0] za;
        runSearch(8'd63, 1'b1, fc, nfc, zc, za, mc);
        checks++;
        if (fc !== 16) begin
            errors++; $display("[TB] FAIL max_key_latency: got cycle %0d, want 16", fc);
        end
        checks++;
        if (found !== 1'b1 || bus.addr !== 5'd31) begin
            errors++; $display("[TB] FAIL max_key_result: found=%b addr=%0d, want 1/31", found, bus.addr);
        end
        checks++;
        if (mc !== 0 || zc !== 0) begin
            errors++; $display("[TB] FAIL max_key_cmds: overlaps=%0d check_zero=%0d, want 0/0", mc, zc);
        end
`ifdef BSC_PROBE_COUNT_EN
        checks++;
        if (probes !== 3'd5) begin
            errors++; $display("[TB] FAIL max_key_probes: got %0d, want 5", probes);
        end
`endif
        dropStart();
    endtask

    task automatic test_key_one();
        int fc, nfc, zc, mc;
        logic [4:0] za;
        runSearch(8'd1, 1'b1, fc, nfc, zc, za, mc);
        checks++;
        if (zc !== 1 || za !== 5'd1) begin
            errors++; $display("[TB] FAIL key_one_check_zero: count=%0d at addr=%0d, want 1 at 1", zc, za);
        end
        checks++;
        if (fc !== 19 || found !== 1'b1 || bus.addr !== 5'd0) begin
            errors++; $display("[TB] FAIL key_one_result: cycle=%0d found=%b addr=%0d, want 19/1/0",
                fc, found, bus.addr);
        end
`ifdef BSC_PROBE_COUNT_EN
        checks++;
        if (probes !== 3'd6) begin
            errors++; $display("[TB] FAIL key_one_probes: got %0d, want 6", probes);
        end
`endif
        dropStart();
    endtask

    task automatic test_not_found();
        int fc, nfc, zc, mc;
        logic [4:0] za;
        runSearch(8'd34, 1'b1, fc, nfc, zc, za, mc);
        checks++;
        if (nfc !== 16 || notFound !== 1'b1 || found !== 1'b0) begin
            errors++; $display("[TB] FAIL not_found_result: cycle=%0d notFound=%b found=%b, want 16/1/0",
                nfc, notFound, found);
        end
        checks++;
        if (zc !== 0) begin
            errors++; $display("[TB] FAIL not_found_check_zero: got %0d, want 0", zc);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.load_data !== 1'b0) begin
            errors++; $display("[TB] FAIL not_found_done: busy=%b load_data=%b, want 0/0", bus.busy, bus.load_data);
        end
`ifdef BSC_PROBE_COUNT_EN
        checks++;
        if (probes !== 3'd5) begin
            errors++; $display("[TB] FAIL not_found_probes: got %0d, want 5", probes);
        end
`endif
        dropStart();
    endtask

    task automatic test_key_zero();
        int fc, nfc, zc, mc;
        logic [4:0] za;
        runSearch(8'd0, 1'b1, fc, nfc, zc, za, mc);
        checks++;
        if (zc !== 1 || nfc !== 19 || notFound !== 1'b1 || found !== 1'b0) begin
            errors++; $display("[TB] FAIL key_zero_result: check_zero=%0d cycle=%0d notFound=%b found=%b, want 1/19/1/0",
                zc, nfc, notFound, found);
        end
        checks++;
        if (mc !== 0) begin
            errors++; $display("[TB] FAIL key_zero_onehot: got %0d overlap cycles, want 0", mc);
        end
`ifdef BSC_PROBE_COUNT_EN
        checks++;
        if (probes !== 3'd6) begin
            errors++; $display("[TB] FAIL key_zero_probes: got %0d, want 6", probes);
        end
`endif
        dropStart();
    endtask

    task automatic test_reset_mid_search();
        int fc, nfc, zc, mc;
        logic [4:0] za;
        keyIn = 8'd63;
        bus.start = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.load_data !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_search_busy: busy=%b load_data=%b, want 1/0", bus.busy, bus.load_data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.load_data !== 1'b1 || bus.data_big !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_search_reset: busy=%b load_data=%b data_big=%b, want 0/1/0",
                bus.busy, bus.load_data, bus.data_big);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        runSearch(8'd33, 1'b0, fc, nfc, zc, za, mc);
        checks++;
        if (fc !== 4 || found !== 1'b1 || bus.addr !== 5'd16) begin
            errors++; $display("[TB] FAIL restart_after_reset: cycle=%0d found=%b addr=%0d, want 4/1/16",
                fc, found, bus.addr);
        end
        dropStart();
    endtask

    task automatic test_start_held();
        int fc, nfc, zc, mc;
        int badCycles;
        logic [4:0] za;
        runSearch(8'd33, 1'b1, fc, nfc, zc, za, mc);
        badCycles = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.load_data !== 1'b0 || found !== 1'b1) badCycles++;
        end
        checks++;
        if (badCycles !== 0) begin
            errors++; $display("[TB] FAIL start_held_no_restart: got %0d bad cycles, want 0", badCycles);
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.load_data !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL start_drop_idle: load_data=%b busy=%b, want 1/0", bus.load_data, bus.busy);
        end
        runSearch(8'd63, 1'b1, fc, nfc, zc, za, mc);
        checks++;
        if (fc !== 16 || found !== 1'b1 || bus.addr !== 5'd31) begin
            errors++; $display("[TB] FAIL start_rerise_search: cycle=%0d found=%b addr=%0d, want 16/1/31",
                fc, found, bus.addr);
        end
        dropStart();
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_first_probe();
        test_max_key();
        test_key_one();
        test_not_found();
        test_key_zero();
        test_reset_mid_search();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
